phold_mc_arbiter: RTL
=====================

# phold_mc_arbiter

Shares one MC port between `NUM_CORES` PHOLD event-processing cores inside `phold`, with round-robin request arbitration. It tags each request's return control with the issuing core's ID, then uses that tag to steer each MC response back to the right core. It also tracks outstanding transactions so that `phold` can tell when the memory interface has drained before it reports GVT.

## Interface
- `NUM_CORES`, 4: requesters, power of 2, 2–8
- `CORE_RTNCTL_WIDTH`, 8: core-side rtnctl bits
- `MC_RTNCTL_WIDTH`, 32: MC rtnctl bits; must be ≥ `CORE_RTNCTL_WIDTH` + `ID_W`
- `ID_W`, derived as clog2(`NUM_CORES`): core ID field width
- `clk` in 1: sole clock
- `rst_n` in 1: reset, asynchronous, active-low
- `core_rq_vld` in N: per-core request valid
- `core_rq_cmd` in 3N, `core_rq_scmd` in 4N, `core_rq_size` in 2N, `core_rq_vadr` in 48N, `core_rq_data` in 64N, `core_rq_rtnctl` in `CORE_RTNCTL_WIDTH`·N: packed per core, core i at slice i
- `core_rq_stall` out N: request not accepted this cycle
- `mc_rq_vld` out 1, `mc_rq_cmd` out 3, `mc_rq_scmd` out 4, `mc_rq_size` out 2, `mc_rq_vadr` out 48, `mc_rq_data` out 64, `mc_rq_rtnctl` out `MC_RTNCTL_WIDTH`: MC request
- `mc_rq_stall` in 1: MC cannot accept
- `mc_rs_vld` in 1, `mc_rs_cmd` in 3, `mc_rs_scmd` in 4, `mc_rs_data` in 64, `mc_rs_rtnctl` in `MC_RTNCTL_WIDTH`: MC response
- `mc_rs_stall` out 1: response not accepted
- `core_rs_vld` out N: one-hot response valid
- `core_rs_cmd` out 3, `core_rs_scmd` out 4, `core_rs_data` out 64, `core_rs_rtnctl` out `CORE_RTNCTL_WIDTH`: broadcast response fields
- `core_rs_stall` in N: per-core response backpressure
- `idle` out 1: nothing outstanding and both registers empty
- `err_bad_id` out 1: sticky flag, set when a response carries an ID ≥ `NUM_CORES`

## Operation
**Transfer rules.** A transfer occurs on each side when valid is high and stall is low.

**Request register (RQ).**
- Single entry.
- `can_load` = !RQ.full | !`mc_rq_stall`, and `outstanding` < 511.

**Round-robin arbitration.**
- Pointer `rr` holds the highest-priority core.
- When `can_load` is high, the first valid core starting from `rr` is granted.
- The granted core is loaded into RQ.
- `rr` then advances to grant+1, mod N.
- `rr` is unchanged when nothing is granted.
- `core_rq_stall[i]` = !(`can_load` & grant==i). This is combinational from `core_rq_vld`, `rr`, RQ state and `mc_rq_stall`.

**Return-control tagging.**
- `mc_rq_rtnctl` = {zeros, grant ID[`ID_W`-1:0], core rtnctl}.
- The core rtnctl occupies bits [`CORE_RTNCTL_WIDTH`-1:0].

**Response register (RS).**
- Single entry.
- `id` = `mc_rs_rtnctl`[`CORE_RTNCTL_WIDTH`+:`ID_W`].
- RS drains when the target core's `core_rs_stall` is low.
- `mc_rs_stall` = RS.full & `core_rs_stall`[RS.id].
- On accept, RS captures cmd, scmd, data, low rtnctl bits and `id`.
- An `id` ≥ `NUM_CORES` is unreachable when N is a power of 2. It is still checked, so that unused upper-bit corruption is caught:
  - if any bits above the ID field are non-zero, the response is dropped and `err_bad_id` is set;
  - `err_bad_id` clears only on reset.
- `core_rs_vld` = RS.full ? (1 << RS.id) : 0.

**Outstanding counter (9-bit).**
- +1 on each MC request transfer.
- −1 on each accepted good response.
- Simultaneous increment and decrement leave the count unchanged.
- The count never underflows: a decrement at 0 is ignored.
- `idle` = (`outstanding`==0) & !RQ.full & !RS.full.

**Reset values.**
- All valids 0, `core_rs_vld` 0, data fields 0.
- `rr`=0, `outstanding`=0, `err_bad_id`=0, `idle`=1.
- `core_rq_stall` follows its equation.

## Timing
- Request latency: accepted at edge k, `mc_rq_vld`=1 in cycle k+1.
- Throughput: one request per cycle while the MC is not stalling.
- While `mc_rq_stall` is high:
  - RQ holds its contents stable;
  - `mc_rq_vld` stays high;
  - all cores are stalled.
- Response latency: accepted at edge k, `core_rs_vld`=1 in cycle k+1. RS holds until drained.
- Throughput: one response per cycle when the target core does not stall.
- **Reset mid-operation:** RQ and RS contents are discarded and the counter clears. In-flight MC responses that arrive after reset are counted as bad-free decrements at 0, so they are ignored.
- The request path and response path are independent, so simultaneous events on both sides do not interact.

## Structure
- Shared package `phold_pkg`: `MC_CMD_RD`/`WR` encodings, the `ID_W` function (clog2), and the rtnctl field offsets.
- One sub-module: `rr_arbiter` (N requests, enable, one-hot grant plus encoded ID, internal pointer).
- Everything else is flat.

## Test plan
- **Single request.** Core 2 issues a rd with vadr=0x1000 and rtnctl=0x5A. Required response:
  - next cycle: `mc_rq_vld`=1, vadr 0x1000, `mc_rq_rtnctl`=0x25A;
  - `outstanding`=1;
  - after the response comes back: `core_rs_vld`=4'b0100, rtnctl 0x5A, `idle`=1.
- **All-core contention.** All 4 cores hold valid from reset. Grants are issued in order 0,1,2,3,0, one per cycle, and each `core_rq_stall` is low exactly in its own grant cycle.
- **MC backpressure.** Hold `mc_rq_stall` high for 5 cycles with RQ full. `mc_rq_*` stays stable, all `core_rq_stall`=1, and `rr` does not change.
- **Response backpressure.** The response targets core 1 while `core_rs_stall`[1]=1 for 3 cycles:
  - `mc_rs_stall` is high for 3 cycles;
  - RS is delivered on the cycle core 1 releases;
  - a response for core 3 arriving during the stall is held off, not lost.
- **Bad tag.** A response arrives with rtnctl bit 31 set. It is dropped, no `core_rs_vld` is raised, `err_bad_id`=1 sticky, and `outstanding` is unchanged.
- **Reset mid-burst.** Drop `rst_n` with RQ full and `outstanding`=3. All valids go low immediately, `outstanding`=0, `rr`=0, and `idle`=1 once `rst_n` is released.

Source files
------------

// File: rtl/phold_pkg.sv
// Shared PHOLD definitions: MC command encodings, return-control field layout
// and the request/response payload records moved through the MC arbiter.
package phold_pkg;

  typedef enum logic [2:0] {
    MC_CMD_RD = 3'd1,
    MC_CMD_WR = 3'd2
  } mc_cmd_e;

  // Width of a core ID field; a single requester still gets one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // The core ID sits directly above the core-owned rtnctl bits.
  function automatic int unsigned rtnctl_id_lsb(input int unsigned core_w);
    return core_w;
  endfunction

  typedef struct packed {
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [1:0]  size;
    logic [47:0] vadr;
    logic [63:0] data;
  } mc_rq_fields_t;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [63:0] data;
  } mc_rs_fields_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer and moves the pointer just past the winner.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_i,
  input  logic           en_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           gnt_vld_o
);

  logic [IDW-1:0] rr_q, rr_d, idx;
  logic           found;

  always_comb begin
    found    = 1'b0;
    gnt_id_o = '0;
    idx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = rr_q + IDW'(i);
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        gnt_id_o = idx;
      end
    end
    gnt_vld_o = en_i & found;
    gnt_o     = gnt_vld_o ? (N'(1) << gnt_id_o) : '0;
    rr_d      = gnt_vld_o ? gnt_id_o + IDW'(1) : rr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end

endmodule

// File: rtl/phold_mc_arbiter.sv
// Shares one MC port between PHOLD cores: round-robin request path with ID
// tagging in rtnctl, tag-steered response path and an outstanding counter.
module phold_mc_arbiter
  import phold_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 4,
  parameter int unsigned CORE_RTNCTL_WIDTH = 8,
  parameter int unsigned MC_RTNCTL_WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CORES-1:0]            core_rq_vld,
  input  logic [3*NUM_CORES-1:0]          core_rq_cmd,
  input  logic [4*NUM_CORES-1:0]          core_rq_scmd,
  input  logic [2*NUM_CORES-1:0]          core_rq_size,
  input  logic [48*NUM_CORES-1:0]         core_rq_vadr,
  input  logic [64*NUM_CORES-1:0]         core_rq_data,
  input  logic [CORE_RTNCTL_WIDTH*NUM_CORES-1:0] core_rq_rtnctl,
  output logic [NUM_CORES-1:0]            core_rq_stall,
  output logic                            mc_rq_vld,
  output logic [2:0]                      mc_rq_cmd,
  output logic [3:0]                      mc_rq_scmd,
  output logic [1:0]                      mc_rq_size,
  output logic [47:0]                     mc_rq_vadr,
  output logic [63:0]                     mc_rq_data,
  output logic [MC_RTNCTL_WIDTH-1:0]      mc_rq_rtnctl,
  input  logic                            mc_rq_stall,
  input  logic                            mc_rs_vld,
  input  logic [2:0]                      mc_rs_cmd,
  input  logic [3:0]                      mc_rs_scmd,
  input  logic [63:0]                     mc_rs_data,
  input  logic [MC_RTNCTL_WIDTH-1:0]      mc_rs_rtnctl,
  output logic                            mc_rs_stall,
  output logic [NUM_CORES-1:0]            core_rs_vld,
  output logic [2:0]                      core_rs_cmd,
  output logic [3:0]                      core_rs_scmd,
  output logic [63:0]                     core_rs_data,
  output logic [CORE_RTNCTL_WIDTH-1:0]    core_rs_rtnctl,
  input  logic [NUM_CORES-1:0]            core_rs_stall,
  output logic                            idle,
  output logic                            err_bad_id
);

  localparam int unsigned ID_W   = id_w(NUM_CORES);
  localparam int unsigned ID_LSB = rtnctl_id_lsb(CORE_RTNCTL_WIDTH);

  logic                         rq_full_q, rq_full_d;
  mc_rq_fields_t                rq_q, rq_d, sel_fields;
  logic [MC_RTNCTL_WIDTH-1:0]   rq_rtnctl_q, rq_rtnctl_d;
  logic [CORE_RTNCTL_WIDTH-1:0] sel_rtnctl;
  logic                         rs_full_q, rs_full_d;
  mc_rs_fields_t                rs_q, rs_d;
  logic [CORE_RTNCTL_WIDTH-1:0] rs_rtnctl_q, rs_rtnctl_d;
  logic [ID_W-1:0]              rs_id_q, rs_id_d;
  logic [8:0]                   outstanding_q, outstanding_d;
  logic                         err_q, err_d;

  logic                         can_load, mc_xfer, gnt_vld;
  logic [NUM_CORES-1:0]         gnt;
  logic [ID_W-1:0]              gnt_id;
  logic                         rs_bad, rs_acc, rs_load, rs_drain, dec;

  // A full RQ may still reload in the same cycle it hands off to the MC.
  assign can_load = (!rq_full_q || !mc_rq_stall) && (outstanding_q != 9'd511);
  assign mc_xfer  = rq_full_q & ~mc_rq_stall;

  rr_arbiter #(.N(NUM_CORES), .IDW(ID_W)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (core_rq_vld),
    .en_i     (can_load),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .gnt_vld_o(gnt_vld)
  );

  assign core_rq_stall = ~gnt;

  always_comb begin
    sel_fields = '0;
    sel_rtnctl = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_fields.cmd  = core_rq_cmd[i*3 +: 3];
        sel_fields.scmd = core_rq_scmd[i*4 +: 4];
        sel_fields.size = core_rq_size[i*2 +: 2];
        sel_fields.vadr = core_rq_vadr[i*48 +: 48];
        sel_fields.data = core_rq_data[i*64 +: 64];
        sel_rtnctl      = core_rq_rtnctl[i*CORE_RTNCTL_WIDTH +: CORE_RTNCTL_WIDTH];
      end
    end
  end

  // Any set bit above the ID field marks a corrupted tag; such responses are
  // consumed from the MC but never delivered or counted.
  assign rs_bad      = |(mc_rs_rtnctl >> (ID_LSB + ID_W));
  assign mc_rs_stall = rs_full_q & core_rs_stall[rs_id_q];
  assign rs_drain    = rs_full_q & ~core_rs_stall[rs_id_q];
  assign rs_acc      = mc_rs_vld & ~mc_rs_stall;
  assign rs_load     = rs_acc & ~rs_bad;
  assign dec         = rs_load & (outstanding_q != 9'd0);

  always_comb begin
    rq_full_d   = rq_full_q;
    rq_d        = rq_q;
    rq_rtnctl_d = rq_rtnctl_q;
    if (gnt_vld) begin
      rq_full_d   = 1'b1;
      rq_d        = sel_fields;
      rq_rtnctl_d = MC_RTNCTL_WIDTH'({gnt_id, sel_rtnctl});
    end else if (mc_xfer) begin
      rq_full_d = 1'b0;
    end

    rs_full_d   = rs_full_q;
    rs_d        = rs_q;
    rs_rtnctl_d = rs_rtnctl_q;
    rs_id_d     = rs_id_q;
    if (rs_load) begin
      rs_full_d   = 1'b1;
      rs_d        = '{cmd: mc_rs_cmd, scmd: mc_rs_scmd, data: mc_rs_data};
      rs_rtnctl_d = mc_rs_rtnctl[CORE_RTNCTL_WIDTH-1:0];
      rs_id_d     = mc_rs_rtnctl[ID_LSB +: ID_W];
    end else if (rs_drain) begin
      rs_full_d = 1'b0;
    end

    outstanding_d = outstanding_q + {8'd0, mc_xfer} - {8'd0, dec};
    err_d         = err_q | (rs_acc & rs_bad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_full_q     <= 1'b0;
      rq_q          <= '0;
      rq_rtnctl_q   <= '0;
      rs_full_q     <= 1'b0;
      rs_q          <= '0;
      rs_rtnctl_q   <= '0;
      rs_id_q       <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      rq_full_q     <= rq_full_d;
      rq_q          <= rq_d;
      rq_rtnctl_q   <= rq_rtnctl_d;
      rs_full_q     <= rs_full_d;
      rs_q          <= rs_d;
      rs_rtnctl_q   <= rs_rtnctl_d;
      rs_id_q       <= rs_id_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign mc_rq_vld      = rq_full_q;
  assign mc_rq_cmd      = rq_q.cmd;
  assign mc_rq_scmd     = rq_q.scmd;
  assign mc_rq_size     = rq_q.size;
  assign mc_rq_vadr     = rq_q.vadr;
  assign mc_rq_data     = rq_q.data;
  assign mc_rq_rtnctl   = rq_rtnctl_q;
  assign core_rs_vld    = rs_full_q ? (NUM_CORES'(1) << rs_id_q) : '0;
  assign core_rs_cmd    = rs_q.cmd;
  assign core_rs_scmd   = rs_q.scmd;
  assign core_rs_data   = rs_q.data;
  assign core_rs_rtnctl = rs_rtnctl_q;
  assign idle           = (outstanding_q == 9'd0) & ~rq_full_q & ~rs_full_q;
  assign err_bad_id     = err_q;

endmodule
